macload_csr_bank: RTL

CSR-side responder for the MAC-load address update interface. It holds the eight MAC-load configuration and address registers: activation/weight address, stride, rollback and skip. It accepts autonomous address write-backs from the MAC-load controller and software CSR accesses from the core's CSR path, and arbitrates when both target the same register. The register values are exported continuously to the MAC-load controller, and two hardware-update counters are kept for debug and performance readout.

---
 rtl/macload_csr_bank.sv | 128 ++++++++++++
 1 files changed

// File: rtl/macload_csr_bank.sv
// CSR bank for the MAC-load address path: eight config/address registers plus two
// saturating hardware-update counters, with software/hardware write arbitration.
module macload_csr_bank #(
    parameter logic [11:0] BASE_ADDR = 12'h7D0
) (
    input  logic        clk_i,
    input  logic        rstn_i,
    input  logic        sw_access_i,
    input  logic [1:0]  sw_op_i,
    input  logic [11:0] sw_addr_i,
    input  logic [31:0] sw_wdata_i,
    output logic [31:0] sw_rdata_o,
    output logic        sw_hit_o,
    input  logic [1:0]  hw_op_i,
    input  logic [11:0] hw_addr_i,
    input  logic [31:0] hw_wdata_i,
    output logic [31:0] a_address_o,
    output logic [31:0] w_address_o,
    output logic [31:0] a_stride_o,
    output logic [31:0] w_stride_o,
    output logic [31:0] a_rollback_o,
    output logic [31:0] w_rollback_o,
    output logic [31:0] a_skip_o,
    output logic [31:0] w_skip_o,
    output logic        hw_drop_o
);

    typedef enum logic [1:0] {
        CSR_OP_NONE  = 2'b00,
        CSR_OP_WRITE = 2'b01,
        CSR_OP_SET   = 2'b10,
        CSR_OP_CLEAR = 2'b11
    } csr_op_e;

    csr_op_e     sw_op;
    csr_op_e     hw_op;
    logic [11:0] sw_off;
    logic [11:0] hw_off;
    logic        sw_wr;
    logic        hw_wr;
    logic        hw_commit;

    logic [31:0] data_q [8];
    logic [31:0] data_d [8];
    logic [31:0] a_upd_cnt_q, a_upd_cnt_d;
    logic [31:0] w_upd_cnt_q, w_upd_cnt_d;
    logic        hw_drop_d;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == '1) ? v : v + 32'd1;
    endfunction

    assign sw_op  = csr_op_e'(sw_op_i);
    assign hw_op  = csr_op_e'(hw_op_i);
    // Offsets wrap below BASE_ADDR, so a single unsigned compare covers the range check
    assign sw_off = sw_addr_i - BASE_ADDR;
    assign hw_off = hw_addr_i - BASE_ADDR;

    assign sw_hit_o  = sw_access_i && (sw_off < 12'd10);
    assign sw_wr     = sw_hit_o && (sw_op != CSR_OP_NONE);
    assign hw_wr     = (hw_op == CSR_OP_WRITE);
    assign hw_commit = hw_wr && (hw_off < 12'd2) && !(sw_wr && (sw_off == hw_off));
    assign hw_drop_d = hw_wr && !hw_commit;

    always_comb begin
        data_d      = data_q;
        a_upd_cnt_d = a_upd_cnt_q;
        w_upd_cnt_d = w_upd_cnt_q;
        if (hw_commit) begin
            if (hw_off[0]) begin
                data_d[1]   = hw_wdata_i;
                w_upd_cnt_d = sat_inc(w_upd_cnt_q);
            end else begin
                data_d[0]   = hw_wdata_i;
                a_upd_cnt_d = sat_inc(a_upd_cnt_q);
            end
        end
        // Software applied last so a counter clear overrides a same-cycle increment
        if (sw_wr) begin
            if (sw_off[3]) begin
                if (sw_off[0]) w_upd_cnt_d = '0;
                else           a_upd_cnt_d = '0;
            end else begin
                case (sw_op)
                    CSR_OP_WRITE: data_d[sw_off[2:0]] = sw_wdata_i;
                    CSR_OP_SET:   data_d[sw_off[2:0]] = data_q[sw_off[2:0]] | sw_wdata_i;
                    CSR_OP_CLEAR: data_d[sw_off[2:0]] = data_q[sw_off[2:0]] & ~sw_wdata_i;
                    default:      data_d[sw_off[2:0]] = data_q[sw_off[2:0]];
                endcase
            end
        end
    end

    always_comb begin
        sw_rdata_o = '0;
        if (sw_hit_o) begin
            case (sw_off[3:0])
                4'd8:    sw_rdata_o = a_upd_cnt_q;
                4'd9:    sw_rdata_o = w_upd_cnt_q;
                default: sw_rdata_o = data_q[sw_off[2:0]];
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            for (int unsigned i = 0; i < 8; i++) data_q[i] <= '0;
            a_upd_cnt_q <= '0;
            w_upd_cnt_q <= '0;
            hw_drop_o   <= 1'b0;
        end else begin
            data_q      <= data_d;
            a_upd_cnt_q <= a_upd_cnt_d;
            w_upd_cnt_q <= w_upd_cnt_d;
            hw_drop_o   <= hw_drop_d;
        end
    end

    assign a_address_o  = data_q[0];
    assign w_address_o  = data_q[1];
    assign a_stride_o   = data_q[2];
    assign w_stride_o   = data_q[3];
    assign a_rollback_o = data_q[4];
    assign w_rollback_o = data_q[5];
    assign a_skip_o     = data_q[6];
    assign w_skip_o     = data_q[7];

endmodule
